// File: rtl/rrf_pkg.sv
// Shared sizing for the retirement register file and its free-return path.
package rrf_pkg;
    localparam int unsigned ARF_DEPTH    = 32;
    localparam int unsigned ARF_IDX      = $clog2(ARF_DEPTH);
    localparam int unsigned PRF_DEPTH    = 64;
    localparam int unsigned PRF_IDX      = $clog2(PRF_DEPTH);
    localparam int unsigned RRF_FQ_DEPTH = 4;
    localparam int unsigned RETIRE_CNT_W = 32;
endpackage

// File: rtl/rrf_free_queue.sv
// Valid/ready FIFO carrying superseded physical registers back to the free list.
module rrf_free_queue #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign push       = push_valid && !full;
    assign pop        = pop_ready && !empty;
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign pop_data   = mem[head[PTR_W-2:0]];

    always_comb begin
        head_nxt = head + PTR_W'(pop);
        tail_nxt = tail + PTR_W'(push);
    end

    // Full/empty are registered from next pointers so the handshake outputs carry no input path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            empty <= (head_nxt == tail_nxt);
            full  <= ((tail_nxt - head_nxt) == PTR_W'(DEPTH));
            if (push) begin
                mem[tail[PTR_W-2:0]] <= push_data;
            end
        end
    end
endmodule

// File: rtl/rrf.sv
// Retirement RAT: installs committed mappings and returns superseded physical registers.
module rrf
    import rrf_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = RRF_FQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rob_valid,
    input  logic [PRF_IDX-1:0]           rob_rd_phy,
    input  logic [ARF_IDX-1:0]           rob_rd_arch,
    output logic                         rob_ready,
    output logic                         fl_valid,
    output logic [PRF_IDX-1:0]           fl_phy,
    input  logic                         fl_ready,
    output logic [ARF_DEPTH*PRF_IDX-1:0] rrat_map,
    output logic [RETIRE_CNT_W-1:0]      retire_count
);
    logic [PRF_IDX-1:0] rrat [ARF_DEPTH];
    logic               commit;
    logic               push;
    logic [PRF_IDX-1:0] old_phy;

    assign commit  = rob_valid && rob_ready;
    assign push    = commit && (rob_rd_arch != '0);
    assign old_phy = rrat[rob_rd_arch];

    // x0 commits still retire but never remap or free anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ARF_DEPTH; i++) begin
                rrat[i] <= PRF_IDX'(i);
            end
            retire_count <= '0;
        end else begin
            if (push) begin
                rrat[rob_rd_arch] <= rob_rd_phy;
            end
            if (commit) begin
                retire_count <= retire_count + RETIRE_CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < ARF_DEPTH; g++) begin : g_map
        assign rrat_map[g*PRF_IDX +: PRF_IDX] = rrat[g];
    end

    rrf_free_queue #(
        .WIDTH (PRF_IDX),
        .DEPTH (FQ_DEPTH)
    ) u_free_queue (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push),
        .push_data  (old_phy),
        .push_ready (rob_ready),
        .pop_valid  (fl_valid),
        .pop_data   (fl_phy),
        .pop_ready  (fl_ready)
    );
endmodule

// File: tb/tb_rrf.sv
// Randomized and directed bench for rrf against a queue/array reference model.
module tb_rrf;
    localparam int unsigned AD = 32;
    localparam int unsigned PW = 6;
    localparam int unsigned FQ = 4;

    logic                 clk;
    logic                 rst;
    logic                 rob_valid;
    logic [PW-1:0]        rob_rd_phy;
    logic [4:0]           rob_rd_arch;
    logic                 rob_ready;
    logic                 fl_valid;
    logic [PW-1:0]        fl_phy;
    logic                 fl_ready;
    logic [AD*PW-1:0]     rrat_map;
    logic [31:0]          retire_count;

    int          n_checks;
    int          n_fail;
    int          mr [AD];
    int          mq [$];
    int          obs [$];
    int unsigned mcnt;
    bit          acc;

    rrf dut (
        .clk          (clk),
        .rst          (rst),
        .rob_valid    (rob_valid),
        .rob_rd_phy   (rob_rd_phy),
        .rob_rd_arch  (rob_rd_arch),
        .rob_ready    (rob_ready),
        .fl_valid     (fl_valid),
        .fl_phy       (fl_phy),
        .fl_ready     (fl_ready),
        .rrat_map     (rrat_map),
        .retire_count (retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [AD*PW-1:0] pack_map();
        logic [AD*PW-1:0] v;
        v = '0;
        for (int i = 0; i < AD; i++) v[i*PW +: PW] = PW'(mr[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < AD; i++) mr[i] = i;
        mq.delete();
        obs.delete();
        mcnt = 0;
    endtask

    task automatic compare_all();
        check("rob_ready", 192'(rob_ready), 192'(mq.size() < FQ));
        check("fl_valid", 192'(fl_valid), 192'(mq.size() != 0));
        if (mq.size() != 0) check("fl_phy", 192'(fl_phy), 192'(mq[0]));
        check("retire_count", 192'(retire_count), 192'(mcnt));
        check("rrat_map", 192'(rrat_map), 192'(pack_map()));
    endtask

    // Called at a falling edge: check state, drive inputs, advance model to the next rising edge.
    task automatic step(input bit v, input int a, input int p, input bit fr, output bit accepted);
        compare_all();
        if (fl_valid && fr) obs.push_back(int'(fl_phy));
        rob_valid   = v;
        rob_rd_arch = 5'(a);
        rob_rd_phy  = 6'(p);
        fl_ready    = fr;
        accepted = v && (mq.size() < FQ);
        if (fr && mq.size() != 0) void'(mq.pop_front());
        if (accepted) begin
            mcnt++;
            if (a != 0) begin
                mq.push_back(mr[a]);
                mr[a] = p;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        logic [AD*PW-1:0] ident;
        for (int i = 0; i < AD; i++) ident[i*PW +: PW] = PW'(i);
        rob_valid = 1'b0;
        fl_ready  = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_fl_valid", 192'(fl_valid), 192'(0));
        check("rst_rob_ready", 192'(rob_ready), 192'(1));
        check("rst_retire_count", 192'(retire_count), 192'(0));
        check("rst_rrat_identity", 192'(rrat_map), 192'(ident));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        for (int k = 0; k < FQ + 2; k++) step(1'b0, 0, 0, 1'b1, acc);
    endtask

    task automatic check_obs(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
        int exp [5];
        exp = '{e0, e1, e2, e3, e4};
        check({tag, "_count"}, 192'(obs.size()), 192'(n));
        for (int i = 0; i < n; i++)
            check(tag, 192'((i < obs.size()) ? obs[i] : 99), 192'(exp[i]));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        rob_valid   = 1'b0;
        rob_rd_phy  = '0;
        rob_rd_arch = '0;
        fl_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_fl_phy", 192'(fl_phy), 192'(0));

        // Single commit
        apply_reset();
        step(1'b1, 5, 40, 1'b1, acc);
        check("single_rrat5", 192'(rrat_map[5*PW +: PW]), 192'(40));
        check("single_fl_valid", 192'(fl_valid), 192'(1));
        check("single_fl_phy", 192'(fl_phy), 192'(5));
        check("single_count", 192'(retire_count), 192'(1));
        step(1'b0, 0, 0, 1'b1, acc);
        check("single_fl_valid_after", 192'(fl_valid), 192'(0));

        // Backpressure
        apply_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, i, 32 + i, 1'b0, acc);
        check("bp_rob_ready_low", 192'(rob_ready), 192'(0));
        step(1'b1, 5, 37, 1'b0, acc);
        check("bp_held", 192'(acc), 192'(0));
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) step(1'b1, 5, 37, 1'b1, acc);
        check("bp_commit5_accepted", 192'(acc), 192'(1));
        drain();
        check_obs("bp_order", 5, 1, 2, 3, 4, 5);
        check("bp_rrat5", 192'(rrat_map[5*PW +: PW]), 192'(37));

        // x0 commit
        apply_reset();
        step(1'b1, 0, 50, 1'b1, acc);
        check("x0_fl_valid", 192'(fl_valid), 192'(0));
        check("x0_count", 192'(retire_count), 192'(1));
        check("x0_rrat0", 192'(rrat_map[0 +: PW]), 192'(0));
        step(1'b0, 0, 0, 1'b1, acc);

        // Rename chain
        apply_reset();
        step(1'b1, 7, 41, 1'b1, acc);
        step(1'b1, 7, 42, 1'b1, acc);
        drain();
        check_obs("chain_order", 2, 7, 41, 0, 0, 0);
        check("chain_rrat7", 192'(rrat_map[7*PW +: PW]), 192'(42));

        // Simultaneous push and pop at one entry
        apply_reset();
        step(1'b1, 3, 20, 1'b0, acc);
        step(1'b1, 4, 21, 1'b1, acc);
        check("sim_fl_valid", 192'(fl_valid), 192'(1));
        check("sim_fl_phy", 192'(fl_phy), 192'(4));
        check("sim_rob_ready", 192'(rob_ready), 192'(1));
        drain();
        check_obs("sim_order", 2, 3, 4, 0, 0, 0);

        // Mid-run reset with three queued
        apply_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, i + 10, 50 + i, 1'b0, acc);
        check("mid_fl_valid_pre", 192'(fl_valid), 192'(1));
        apply_reset();
        step(1'b0, 0, 0, 1'b1, acc);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int  a;
            int  p;
            bit  in_map;
            a = int'($urandom_range(31));
            do begin
                p = int'($urandom_range(63));
                in_map = 1'b0;
                for (int i = 1; i < AD; i++) if (mr[i] == p) in_map = 1'b1;
            end while (a != 0 && in_map);
            step(($urandom_range(99) < 70), a, p, ($urandom_range(99) < 45), acc);
        end
        compare_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rrf.md
Name: rrf

Overview:
- Retirement register file: the receiving end of the ROB commit channel.
- Holds the architectural-to-physical mapping of committed state (retirement RAT).
- On each commit it installs the new mapping and returns the superseded physical register to the free list through a small return queue.
- Sits between the ROB commit port and the free list; it also exports the committed map for later recovery use.

Parameters:
- ARF_DEPTH, 32, number of architectural registers
- ARF_IDX, 5, architectural index width (clog2 ARF_DEPTH)
- PRF_IDX, 6, physical index width (PRF_DEPTH = 64)
- FQ_DEPTH, 4, depth of the free-return queue (power of 2, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rob_valid  in  1  ROB presents a committing instruction
- rob_rd_phy  in  PRF_IDX  new physical destination
- rob_rd_arch  in  ARF_IDX  architectural destination
- rob_ready  out  1  commit can be accepted this cycle
- fl_valid  out  1  a freed physical register is offered
- fl_phy  out  PRF_IDX  freed physical register index
- fl_ready  in  1  free list accepts fl_phy
- rrat_map  out  ARF_DEPTH*PRF_IDX  committed map, entry i at bits [i*PRF_IDX +: PRF_IDX]
- retire_count  out  32  number of accepted commits, wraps mod 2^32

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high; all state clears immediately on assertion, independent of clk.
- Reset values:
  - rrat[i] = i for all i (identity map)
  - queue empty, count = 0
  - fl_valid = 0, fl_phy = 0
  - retire_count = 0
  - rob_ready = 1 once reset deasserts
- Commit handshake:
  - A commit is accepted when rob_valid && rob_ready.
  - rob_ready = (count < FQ_DEPTH). It is purely registered state, with no combinational path from fl_ready or rob_valid.
  - The ROB holds its head until accepted.
- Accepted commit with rob_rd_arch != 0:
  - old = rrat[rob_rd_arch], read before the update.
  - rrat[rob_rd_arch] <= rob_rd_phy.
  - old is pushed into the queue tail.
  - retire_count increments.
- Accepted commit with rob_rd_arch == 0:
  - rrat is unchanged and nothing is pushed.
  - retire_count still increments.
- Free queue:
  - FIFO with head/tail pointers of width clog2(FQ_DEPTH)+1; the wrap flag bit distinguishes full from empty.
  - fl_valid = !empty; fl_phy = entry at head. Both are driven from registered state only.
  - Pop occurs when fl_valid && fl_ready.
- Latency: commit accepted in cycle N gives fl_valid and fl_phy = old in cycle N+1 (queue empty beforehand), and rrat_map reflects the new entry in N+1.
- Simultaneous push and pop in one cycle: both occur and count is unchanged.
  - When full, no push can occur (rob_ready = 0), so a pop that cycle raises rob_ready in the next cycle.
- Ordering: freed registers leave in commit order.
- Assertions (bench-side):
  - No push when full.
  - No pop when empty.
  - rob_rd_phy must not equal any current rrat entry for arch != 0.
- X handling: rob_rd_phy and rob_rd_arch are ignored when rob_valid = 0. fl_phy is don't-care when fl_valid = 0; the RTL drives head data.
- Reset mid-operation: queued freed registers are discarded. The free list is reset in the same cycle and rebuilds its own contents.

Decomposition:
- cpu_params package: ARF_DEPTH, ARF_IDX, PRF_DEPTH, PRF_IDX; add RRF_FQ_DEPTH there.
- rob_rrf_itf gains a ready modport signal mapped to rob_ready.
- New rrf_fl_itf (valid, phy, ready) for the free-list side.
- One natural sub-module: rrf_free_queue, a parameterised valid/ready FIFO with async reset, holding the pointer logic.
- rrf top holds the RAT, retire_count and the commit datapath.

Test Plan:
- Reset: assert rst asynchronously between edges -> rrat_map entry i = i for all 32, fl_valid = 0, rob_ready = 1, retire_count = 0 before the next edge.
- Single commit: arch 5, phy 40, fl_ready = 1 -> next cycle rrat[5] = 40, fl_valid = 1, fl_phy = 5, retire_count = 1; the cycle after, fl_valid = 0.
- Backpressure: fl_ready = 0, commit arch 1..5 with phys 33..37 on consecutive cycles ->
  - 4 accepted, rob_ready = 0 from the cycle after the 4th
  - on raising fl_ready, fl_phy sequence 1, 2, 3, 4, then commit 5 is accepted
- x0 commit: arch 0, phy 50 -> rrat_map unchanged, fl_valid stays 0, retire_count increments.
- Rename chain: commit arch 7 phy 41, then arch 7 phy 42 -> fl_phy sequence 7, 41; rrat[7] = 42.
- Simultaneous push and pop at count = 1 -> count stays 1, FIFO order preserved.
- Mid-run reset with 3 entries queued -> fl_valid = 0 immediately, identity map restored.
